// File: rtl/jtpang_objdma.sv
`default_nettype none
// ============================================================================
//  Module   : jtpang_objdma
//  Purpose  : Object DMA engine. On a CPU DMA trigger it requests the Z80
//             bus, copies LEN bytes of the object table from shared video
//             RAM into the object line buffer, then releases the bus.
//  Revision : 1.0  initial release
// ============================================================================
module jtpang_objdma #(
  parameter int              AW       = 12,
  parameter logic [AW-1:0]   SRC_BASE = '0,
  parameter int              LEN      = 512,
  parameter int              OW       = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq_n,
  output logic          dma_cs,
  output logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic          obj_we,
  output logic [OW-1:0] obj_addr,
  output logic [7:0]    obj_dout,
  output logic          busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_REL   = 3'd4;

  localparam logic [AW-1:0] LAST_RD = AW'(LEN - 1);

  logic [2:0]    state_q;
  logic          pending_q;
  logic          go_q;
  logic [AW-1:0] rd_q;
  logic [OW-1:0] wr_q;
  logic          busrq_n_q;
  logic          dma_cs_q;
  logic [AW-1:0] dma_addr_q;
  logic          obj_we_q;
  logic [OW-1:0] obj_addr_q;
  logic [7:0]    obj_dout_q;
  logic          busy_q;
  logic          go_edge;

  // The trigger is a rising edge of dma_go seen at full clock rate, so a
  // short CPU I/O cycle between two cen pulses is never missed.
  assign go_edge = dma_go & ~go_q;

  // Edge detector history, sampled every clk regardless of cen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) go_q <= 1'b0;
    else     go_q <= dma_go;
  end

  // Transfer FSM, read/write pipeline and trigger bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      busrq_n_q  <= 1'b1;
      dma_cs_q   <= 1'b0;
      dma_addr_q <= SRC_BASE;
      obj_we_q   <= 1'b0;
      obj_addr_q <= '0;
      obj_dout_q <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      if (cen) begin
        // A read presented on the previous cen delivers its byte now. This
        // also completes an in-flight read when the bus is lost.
        obj_we_q <= dma_cs_q;
        if (dma_cs_q) begin
          obj_addr_q <= wr_q;
          obj_dout_q <= dma_din;
          wr_q       <= wr_q + 1'b1;
        end
        case (state_q)
          ST_IDLE: begin
            if (go_edge || pending_q) begin
              state_q   <= ST_REQ;
              busy_q    <= 1'b1;
              busrq_n_q <= 1'b0;
            end
          end
          ST_REQ: begin
            if (!busak_n) begin
              state_q <= ST_XFER;
              rd_q    <= '0;
              wr_q    <= '0;
            end
          end
          ST_XFER: begin
            if (!busak_n) begin
              dma_cs_q   <= 1'b1;
              dma_addr_q <= SRC_BASE + rd_q;
              rd_q       <= rd_q + 1'b1;
              if (rd_q == LAST_RD) state_q <= ST_DRAIN;
            end else begin
              // Bus taken back: stop reading, keep counters and request.
              dma_cs_q <= 1'b0;
            end
          end
          ST_DRAIN: begin
            dma_cs_q  <= 1'b0;
            busrq_n_q <= 1'b1;
            state_q   <= ST_REL;
          end
          ST_REL: begin
            if (busak_n) begin
              state_q <= ST_IDLE;
              // Stay busy when another transfer is already queued.
              busy_q  <= pending_q | go_edge;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
      // IDLE on a cen consumes any queued or fresh trigger; otherwise an
      // edge queues one transfer and further edges are absorbed.
      if (cen && state_q == ST_IDLE) pending_q <= 1'b0;
      else if (go_edge)              pending_q <= 1'b1;
    end
  end

  assign busrq_n  = busrq_n_q;
  assign dma_cs   = dma_cs_q;
  assign dma_addr = dma_addr_q;
  assign obj_we   = obj_we_q & cen;
  assign obj_addr = obj_addr_q;
  assign obj_dout = obj_dout_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_jtpang_objdma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_jtpang_objdma
//  Purpose  : Directed self-checking bench for jtpang_objdma (512-byte and
//             4-byte configurations) with a Z80 bus-grant model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtpang_objdma;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic cen = 1'b1;
  int   cen_div = 1;
  int   cen_cnt = 0;

  // Instance A: default 512-byte configuration
  logic        go_a = 1'b0, busak_a = 1'b1;
  logic        busrq_a, cs_a, we_a, busy_a;
  logic [11:0] addr_a;
  logic [7:0]  din_a, dout_a;
  logic [8:0]  oaddr_a;

  // Instance B: 4-byte table at 0x010
  logic        go_b = 1'b0, busak_b = 1'b1;
  logic        busrq_b, cs_b, we_b, busy_b;
  logic [11:0] addr_b;
  logic [7:0]  din_b, dout_b;
  logic [1:0]  oaddr_b;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Video RAM contents for instance A
  function automatic logic [7:0] ref_byte(input logic [11:0] a);
    logic [11:0] t;
    t = a * 12'd3;
    return t[7:0] ^ {4'h5, a[11:8]};
  endfunction

  logic [7:0] tbl_b [4] = '{8'd11, 8'd22, 8'd33, 8'd44};

  assign din_a = ref_byte(addr_a);
  assign din_b = (addr_b[11:2] == 10'h004) ? tbl_b[addr_b[1:0]] : 8'hEE;

  jtpang_objdma dut_a (
    .clk(clk), .rst(rst), .cen(cen), .dma_go(go_a), .busak_n(busak_a),
    .busrq_n(busrq_a), .dma_cs(cs_a), .dma_addr(addr_a), .dma_din(din_a),
    .obj_we(we_a), .obj_addr(oaddr_a), .obj_dout(dout_a), .busy(busy_a)
  );

  jtpang_objdma #(.AW(12), .SRC_BASE(12'h010), .LEN(4), .OW(2)) dut_b (
    .clk(clk), .rst(rst), .cen(cen), .dma_go(go_b), .busak_n(busak_b),
    .busrq_n(busrq_b), .dma_cs(cs_b), .dma_addr(addr_b), .dma_din(din_b),
    .obj_we(we_b), .obj_addr(oaddr_b), .obj_dout(dout_b), .busy(busy_b)
  );

  // Monitors, bus models and cen generation. At the start of this block cen
  // still holds the value that applied at the preceding rising edge.
  int   ak_cnt = 0;
  bit   hold_a = 1'b0;
  int   nwr_a = 0;
  int   exp_wr_a = 0;
  int   cen_idx = 0;
  int   nwr_b = 0;
  int   b_idx [4];
  logic [7:0] b_dat [4];
  logic [1:0] b_adr [4];

  always @(negedge clk) begin
    if (rst) exp_wr_a = 0;
    if (we_a) begin
      chk("wr_addr", 32'(oaddr_a), 32'(exp_wr_a));
      chk("wr_data", 32'(dout_a), 32'(ref_byte(12'(exp_wr_a))));
      nwr_a++;
      exp_wr_a = (exp_wr_a + 1) % 512;
    end
    if (we_b) begin
      if (nwr_b < 4) begin
        b_idx[nwr_b] = cen_idx;
        b_dat[nwr_b] = dout_b;
        b_adr[nwr_b] = oaddr_b;
      end
      nwr_b++;
    end
    if (cen) begin
      if (hold_a) begin
        busak_a = 1'b1;
        ak_cnt  = 2;
      end else if (busrq_a) begin
        busak_a = 1'b1;
        ak_cnt  = 0;
      end else if (busak_a) begin
        if (ak_cnt == 2) busak_a = 1'b0;
        else ak_cnt++;
      end
      busak_b = busrq_b;
      cen_idx++;
    end
    cen_cnt = (cen_cnt + 1 >= cen_div) ? 0 : cen_cnt + 1;
    cen = (cen_cnt == 0);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input int max);
    int n;
    n = 0;
    while (busy_a && n < max) begin
      tick();
      n++;
    end
    chk("idle_a_timeout", 32'(busy_a), 32'd0);
  endtask

  task automatic pulse_a();
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, run, first_run;
    bit saw_low, ak_at_idle;

    repeat (3) tick();
    chk("rst_busrq_n", 32'(busrq_a), 32'd1);
    chk("rst_dma_cs",  32'(cs_a),    32'd0);
    chk("rst_obj_we",  32'(we_a),    32'd0);
    chk("rst_busy",    32'(busy_a),  32'd0);
    chk("rst_dma_addr",32'(addr_a),  32'h000);
    chk("rst_obj_addr",32'(oaddr_a), 32'd0);
    chk("rst_obj_dout",32'(dout_a),  32'd0);
    chk("rst_b_addr",  32'(addr_b),  32'h010);
    rst = 1'b0;
    tick();

    // Single full transfer
    base = nwr_a;
    pulse_a();
    chk("t1_busrq_low", 32'(busrq_a), 32'd0);
    chk("t1_busy",      32'(busy_a),  32'd1);
    wait_idle_a(3000);
    chk("t1_count",     32'(nwr_a - base), 32'd512);
    chk("t1_busrq_rel", 32'(busrq_a), 32'd1);

    // Retrigger at write #100: queued second copy
    base = nwr_a;
    pulse_a();
    n = 0;
    while (nwr_a - base < 100 && n < 2000) begin tick(); n++; end
    chk("t2_at100", 32'(nwr_a - base), 32'd100);
    pulse_a();
    run = 0; first_run = -1; saw_low = 1'b0; n = 0;
    while (nwr_a - base < 1024 && n < 4000) begin
      tick();
      n++;
      if (!busy_a) saw_low = 1'b1;
      if (busrq_a) run++;
      else if (run > 0 && first_run < 0) first_run = run;
    end
    chk("t2_busy_held", 32'(saw_low), 32'd0);
    chk("t2_rerequest_gap", 32'(first_run), 32'd2);
    wait_idle_a(100);
    chk("t2_count", 32'(nwr_a - base), 32'd1024);

    // Bus stolen around rd=200
    base = nwr_a;
    pulse_a();
    n = 0;
    while (!(cs_a && addr_a == 12'd199) && n < 2000) begin tick(); n++; end
    hold_a = 1'b1;
    tick();
    chk("stall_issue200", 32'(addr_a), 32'd200);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_cs",    32'(cs_a),    32'd0);
      chk("stall_addr",  32'(addr_a),  32'd200);
      chk("stall_busrq", 32'(busrq_a), 32'd0);
    end
    hold_a = 1'b0;
    tick();
    chk("stall_cs_last",  32'(cs_a), 32'd0);
    chk("stall_writes",   32'(nwr_a - base), 32'd201);
    tick();
    chk("resume_addr", 32'(addr_a), 32'd201);
    chk("resume_cs",   32'(cs_a),   32'd1);
    wait_idle_a(3000);
    chk("stall_count", 32'(nwr_a - base), 32'd512);

    // Reset at write #50
    base = nwr_a;
    pulse_a();
    n = 0;
    while (nwr_a - base < 50 && n < 2000) begin tick(); n++; end
    chk("rst50_at50", 32'(nwr_a - base), 32'd50);
    rst = 1'b1;
    #1;
    chk("rst50_busrq", 32'(busrq_a), 32'd1);
    chk("rst50_busy",  32'(busy_a),  32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("rst50_idle", 32'(busy_a), 32'd0);
    base = nwr_a;
    pulse_a();
    wait_idle_a(3000);
    chk("rst50_count", 32'(nwr_a - base), 32'd512);

    // dma_go held high for 40 clk: exactly one transfer
    base = nwr_a;
    go_a = 1'b1;
    repeat (40) tick();
    go_a = 1'b0;
    wait_idle_a(3000);
    repeat (200) tick();
    chk("held_busy",  32'(busy_a), 32'd0);
    chk("held_count", 32'(nwr_a - base), 32'd512);

    // Instance B at cen = clk/8
    cen_div = 8;
    repeat (10) tick();
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    n = 0;
    while (!busy_b && n < 50) begin tick(); n++; end
    chk("b_busy_high", 32'(busy_b), 32'd1);
    n = 0; ak_at_idle = 1'b0;
    while (busy_b && n < 1000) begin tick(); n++; end
    ak_at_idle = busak_b;
    chk("b_busy_low", 32'(busy_b), 32'd0);
    chk("b_busak_at_idle", 32'(ak_at_idle), 32'd1);
    chk("b_count", 32'(nwr_b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("b_data", 32'(b_dat[i]), 32'(tbl_b[i]));
      chk("b_addr", 32'(b_adr[i]), 32'(i));
      if (i > 0) chk("b_consecutive", 32'(b_idx[i] - b_idx[i-1]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
